// File: rtl/axis_pkt_pkg.sv
// Shared types for the AXI-Stream packet framer and its output skid buffer.
package axis_pkt_pkg;

  // Default stream geometry; the beat struct below is sized from these.
  localparam int DATA_WIDTH = 32;
  localparam int KEEP_W     = DATA_WIDTH / 8;

  // Framer state: IDLE waits for the first beat of a packet, RUN is mid-packet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  // One stream beat as carried through the skid buffer.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_W-1:0]     tkeep;
    logic                  tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_pkt_framer_if.sv
// AXI-Stream bundle with master (source) and slave (sink) views.
interface axis_pkt_framer_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: one output register plus one overflow register.
// Ready toward the source is a flop, so there is no combinational path
// from the sink's ready back to the source. Latency is one cycle and a
// beat per cycle is sustained while the sink keeps ready high.
module axis_skid_buf #(
  parameter int W = 37
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_busy
);

  logic [W-1:0] r_out_data;
  logic         r_out_valid;
  logic [W-1:0] r_sk_data;
  logic         r_sk_valid;
  logic         r_ready;

  logic [W-1:0] w_out_data_nxt;
  logic         w_out_valid_nxt;
  logic [W-1:0] w_sk_data_nxt;
  logic         w_sk_valid_nxt;
  logic         w_in_fire;
  logic         w_out_fire;

  // Next-state of both entries: refill the output slot from the overflow
  // slot first, otherwise from the input; park input in overflow on a stall.
  always_comb begin
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_sk_data_nxt   = r_sk_data;
    w_sk_valid_nxt  = r_sk_valid;
    w_in_fire       = i_valid & r_ready;
    w_out_fire      = r_out_valid & i_ready;
    if (!r_out_valid || w_out_fire) begin
      if (r_sk_valid) begin
        w_out_data_nxt  = r_sk_data;
        w_out_valid_nxt = 1'b1;
        w_sk_data_nxt   = i_data;
        w_sk_valid_nxt  = w_in_fire;
      end else if (w_in_fire) begin
        w_out_data_nxt  = i_data;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else begin
      if (w_in_fire) begin
        w_sk_data_nxt  = i_data;
        w_sk_valid_nxt = 1'b1;
      end else begin
        w_sk_valid_nxt = r_sk_valid;
      end
    end
  end

  // Entry registers and the registered ready (high whenever overflow is free).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data  <= {W{1'b0}};
      r_out_valid <= 1'b0;
      r_sk_data   <= {W{1'b0}};
      r_sk_valid  <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_sk_data   <= w_sk_data_nxt;
      r_sk_valid  <= w_sk_valid_nxt;
      r_ready     <= ~w_sk_valid_nxt;
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_out_data;
  assign o_valid = r_out_valid;
  assign o_busy  = r_out_valid | r_sk_valid;

endmodule

// File: rtl/axis_pkt_framer.sv
// Packet framer in front of a DMA S2MM stream: counts beats, forces tlast
// every cfg_pkt_len beats (or closes early on upstream tlast), registers
// the stream through a skid buffer and counts completed packets.
module axis_pkt_framer
  import axis_pkt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16,
  parameter int CNT_W      = 32
) (
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              cfg_en,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  axis_pkt_framer_if.slave  s_axis,
  axis_pkt_framer_if.master m_axis,
  output logic [CNT_W-1:0]  stat_pkt_cnt,
  output logic              busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PAY_W = DATA_WIDTH + BYTES + 1;

  fsm_t             r_state;
  fsm_t             w_state_nxt;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [LEN_W-1:0] w_beat_cnt_nxt;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] w_len_q_nxt;
  logic [LEN_W-1:0] w_len_eff;
  logic             w_gate;
  logic             w_close;
  logic             w_in_fire;
  logic             w_skid_ready;
  logic             w_skid_busy;
  logic             w_m_valid;
  logic [PAY_W-1:0] w_in_pay;
  logic [PAY_W-1:0] w_out_pay;
  logic [CNT_W-1:0] r_stat;

  // Framing decision: the first beat of a packet uses the live length,
  // later beats the length latched at packet start; cfg_en only gates
  // the start of a new packet.
  always_comb begin
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_len_q_nxt    = r_len_q;
    w_gate         = 1'b0;
    w_len_eff      = r_len_q;
    case (r_state)
      IDLE: begin
        w_gate    = cfg_en;
        w_len_eff = cfg_pkt_len;
      end
      RUN: begin
        w_gate    = 1'b1;
        w_len_eff = r_len_q;
      end
      default: begin
        w_gate    = 1'b0;
        w_len_eff = r_len_q;
      end
    endcase
    w_in_fire = s_axis.tvalid & w_gate & w_skid_ready;
    // Length 0 never forces a close, so the wrapping counter is harmless.
    w_close   = ((w_len_eff != {LEN_W{1'b0}}) && (r_beat_cnt == (w_len_eff - LEN_W'(1))))
                || s_axis.tlast;
    if (w_in_fire) begin
      if (r_state == IDLE) begin
        w_len_q_nxt = cfg_pkt_len;
      end else begin
        w_len_q_nxt = r_len_q;
      end
      if (w_close) begin
        w_state_nxt    = IDLE;
        w_beat_cnt_nxt = {LEN_W{1'b0}};
      end else begin
        w_state_nxt    = RUN;
        w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
      end
    end else begin
      w_state_nxt    = r_state;
      w_beat_cnt_nxt = r_beat_cnt;
    end
  end

  // FSM, beat counter and latched packet length.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= {LEN_W{1'b0}};
      r_len_q    <= {LEN_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_len_q    <= w_len_q_nxt;
    end
  end

  assign w_in_pay      = {s_axis.tdata, s_axis.tkeep, w_close};
  assign s_axis.tready = w_gate & w_skid_ready;

  axis_skid_buf #(
    .W (PAY_W)
  ) u_skid (
    .i_clk   (axis_clk),
    .i_rst   (axis_rst),
    .i_data  (w_in_pay),
    .i_valid (s_axis.tvalid & w_gate),
    .o_ready (w_skid_ready),
    .o_data  (w_out_pay),
    .o_valid (w_m_valid),
    .i_ready (m_axis.tready),
    .o_busy  (w_skid_busy)
  );

  assign m_axis.tdata  = w_out_pay[PAY_W-1 -: DATA_WIDTH];
  assign m_axis.tkeep  = w_out_pay[BYTES:1];
  assign m_axis.tlast  = w_out_pay[0];
  assign m_axis.tvalid = w_m_valid;

  // Completed-packet counter: one count per tlast handshake, wrapping.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_stat <= {CNT_W{1'b0}};
    end else if (w_m_valid & m_axis.tready & w_out_pay[0]) begin
      r_stat <= r_stat + CNT_W'(1);
    end else begin
      r_stat <= r_stat;
    end
  end

  assign stat_pkt_cnt = r_stat;
  assign busy         = (r_state == RUN) | w_skid_busy;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Scoreboard bench for axis_pkt_framer: the driver predicts each accepted
// beat from a packet-level model and queues it; a monitor compares every
// beat leaving m_axis against the queue.
module tb_axis_pkt_framer;
  import axis_pkt_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_en;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] stat;
  logic          busy;

  axis_pkt_framer_if #(.DATA_WIDTH(DW)) s_if ();
  axis_pkt_framer_if #(.DATA_WIDTH(DW)) m_if ();

  axis_pkt_framer #(.DATA_WIDTH(DW), .LEN_W(LW), .CNT_W(CW)) dut (
    .axis_clk     (clk),
    .axis_rst     (rst),
    .cfg_en       (cfg_en),
    .cfg_pkt_len  (cfg_len),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .stat_pkt_cnt (stat),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    axis_beat_t beat;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;
  int   ready_mode = 1;   // 0: hold low, 1: hold high, 2: random
  int   exp_pkts = 0;
  bit   m_open = 1'b0;    // model: a packet is open
  int   m_pos = 0;        // model: beats already in the open packet
  int   m_len = 0;        // model: length captured at packet start
  logic rdy_snap;

  // Cycle counter used for the latency check.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Packet model: a packet ends after exactly len beats (len!=0) or on upstream tlast.
  function automatic void model_push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    logic last;
    if (!m_open) begin
      m_len  = int'(cfg_len);
      m_pos  = 0;
      m_open = 1'b1;
    end
    last = l || ((m_len != 0) && (m_pos + 1 == m_len));
    e.beat.tdata = d;
    e.beat.tkeep = k;
    e.beat.tlast = last;
    e.cyc = cyc + 1;
    sb.push_back(e);
    if (last) m_open = 1'b0;
    else      m_pos++;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int w;
    bit done;
    w = 0;
    done = 1'b0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (s_if.tready) begin
        model_push(d, k, l);
        done = 1'b1;
      end else begin
        w++;
        if (w > 300) begin
          vecs++;
          errs++;
          $display("FAIL send_timeout: got no tready, expected tready for data %0h", d);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_busy", 64'(busy), 64'(0));
    check("drain_queue_empty", 64'(sb.size()), 64'(0));
  endtask

  // Downstream ready generator; in random mode also confirms s_axis tready
  // does not move when only m_axis tready changes.
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: m_if.tready = 1'b0;
        1: m_if.tready = 1'b1;
        default: begin
          rdy_snap = s_if.tready;
          m_if.tready = ~m_if.tready;
          #1;
          check("s_tready_indep_of_m_tready", 64'(s_if.tready), 64'(rdy_snap));
          m_if.tready = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // Monitor: hold-stability while stalled and in-order comparison on handshakes.
  initial begin
    axis_beat_t cur;
    axis_beat_t prev;
    exp_t e;
    bit prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur.tdata = m_if.tdata;
        cur.tkeep = m_if.tkeep;
        cur.tlast = m_if.tlast;
        if (prev_stall) begin
          check("stall_hold_valid", 64'(m_if.tvalid), 64'(1));
          check("stall_hold_payload", 64'(cur), 64'(prev));
        end
        if (m_if.tvalid && m_if.tready) begin
          if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_beat: got %0h expected no beat", cur);
          end else begin
            e = sb.pop_front();
            check("beat", 64'(cur), 64'(e.beat));
            if (lat_chk) check("latency_1cycle", 64'(cyc), 64'(e.cyc));
            if (e.beat.tlast) exp_pkts++;
          end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev = cur;
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st0;
    rst = 1'b1;
    cfg_en = 1'b1;
    cfg_len = 16'd4;
    s_if.tdata = 32'd0;
    s_if.tkeep = 4'd0;
    s_if.tlast = 1'b0;
    s_if.tvalid = 1'b0;
    idle(3);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_m_tlast", 64'(m_if.tlast), 64'(0));
    check("rst_m_tdata", 64'(m_if.tdata), 64'(0));
    check("rst_m_tkeep", 64'(m_if.tkeep), 64'(0));
    check("rst_stat", 64'(stat), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_s_tready", 64'(s_if.tready), 64'(0));
    rst = 1'b0;
    idle(2);

    // Fixed length 4, continuous, with one-cycle latency check.
    lat_chk = 1'b1;
    for (int i = 0; i < 12; i++) send(32'(i), 4'hF, 1'b0);
    drain();
    lat_chk = 1'b0;
    check("t1_stat", 64'(stat), 64'(3));

    // Early upstream tlast, then a full 8-beat packet.
    cfg_len = 16'd8;
    for (int i = 0; i < 5; i++) send(32'(100 + i), 4'hF, (i == 4));
    for (int i = 0; i < 8; i++) send(32'(200 + i), 4'h3, 1'b0);
    drain();
    check("t2_stat", 64'(stat), 64'(5));

    // Random backpressure, length 3.
    cfg_len = 16'd3;
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(0, 1));
      send($urandom, 4'($urandom), 1'b0);
    end
    drain();
    ready_mode = 1;
    idle(2);
    check("t3_stat", 64'(stat), 64'(15));

    // Length change mid-packet applies to the next packet only.
    cfg_len = 16'd4;
    send(32'h400, 4'hF, 1'b0);
    send(32'h401, 4'hF, 1'b0);
    cfg_len = 16'd2;
    for (int i = 2; i < 10; i++) send(32'h400 + 32'(i), 4'hF, 1'b0);
    drain();
    check("t4_stat", 64'(stat), 64'(19));

    // Enable dropped mid-packet: packet finishes, then input is held off.
    cfg_len = 16'd4;
    send(32'h500, 4'hF, 1'b0);
    send(32'h501, 4'hF, 1'b0);
    cfg_en = 1'b0;
    send(32'h502, 4'hF, 1'b0);
    send(32'h503, 4'hF, 1'b0);
    s_if.tdata = 32'hDEAD;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_tready_gated", 64'(s_if.tready), 64'(0));
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    cfg_en = 1'b1;
    drain();
    check("t5_stat", 64'(stat), 64'(20));

    // Randomised traffic against the model.
    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) cfg_len = 16'($urandom_range(0, 5));
      idle($urandom_range(0, 2));
      send($urandom, 4'($urandom), ($urandom_range(0, 7) == 0));
    end
    send(32'hFFFF, 4'h1, 1'b1);
    drain();
    ready_mode = 1;
    idle(2);
    check("rand_stat", 64'(stat), 64'(exp_pkts));

    // Length 0 over a counter wrap: no forced tlast, then counting restarts.
    st0 = int'(stat);
    cfg_len = 16'd0;
    for (int i = 0; i < 70000; i++) send(32'(i), 4'hF, 1'b0);
    cfg_len = 16'd4;
    send(32'h7000_0000, 4'h1, 1'b1);
    for (int i = 0; i < 4; i++) send(32'h7100_0000 + 32'(i), 4'hF, 1'b0);
    drain();
    check("t6_stat", 64'(stat), 64'(st0 + 2));

    // Reset while beats are buffered and a packet is open.
    ready_mode = 0;
    idle(2);
    send(32'h800, 4'hF, 1'b0);
    send(32'h801, 4'hF, 1'b0);
    check("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    check("mid_rst_stat", 64'(stat), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_s_tready", 64'(s_if.tready), 64'(0));
    rst = 1'b0;
    sb.delete();
    m_open = 1'b0;
    exp_pkts = 0;
    ready_mode = 1;
    idle(2);
    for (int i = 0; i < 4; i++) send(32'h900 + 32'(i), 4'hF, 1'b0);
    drain();
    check("post_rst_stat", 64'(stat), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
